// File: rtl/inst_fifo.sv
// inst_fifo: instruction queue between fetch and issue; up to two writes and two pops per cycle.
// Define INST_FIFO_COUNT_EN to expose the registered occupancy on fifo_count.
module inst_fifo #(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [63:0] w_data_1,
   input  logic        w_data_1_ok,
   input  logic [63:0] w_data_2,
   input  logic        w_data_2_ok,
   output logic        fifo_full,
   output logic [63:0] fifo_r_data_1,
   output logic        fifo_r_data_1_ok,
   output logic [63:0] fifo_r_data_2,
   output logic        fifo_r_data_2_ok,
   input  logic        p_data_1,
   input  logic        p_data_2
`ifdef INST_FIFO_COUNT_EN
   ,
   output logic [PTR_W:0] fifo_count
`endif
);

   localparam logic [PTR_W:0] FULL_ABOVE = (PTR_W+1)'(DEPTH - 2);
   localparam logic [PTR_W:0] ONE_ENTRY  = (PTR_W+1)'(1);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [63:0]      mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_p1;
   logic [PTR_W-1:0] rd_ptr_p1;
   logic             rd_ok_1;
   logic             rd_ok_2;
   logic             full;
   logic             we_1;
   logic             we_2;
   logic [1:0]       nw;
   logic [1:0]       np;

   assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
   assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);

   // Status comes only from registered count, so no input reaches an output combinationally.
   assign rd_ok_1 = (count_q != '0);
   assign rd_ok_2 = (count_q > ONE_ENTRY);
   assign full    = (count_q > FULL_ABOVE);

   always_comb begin
      we_1 = 1'b0;
      we_2 = 1'b0;
      nw   = 2'd0;
      np   = 2'd0;
      if (!flush && !full && w_data_1_ok) begin
         we_1 = 1'b1;
         we_2 = w_data_2_ok;
         nw   = w_data_2_ok ? 2'd2 : 2'd1;
      end
      if (!flush && p_data_1 && rd_ok_1) begin
         np = (p_data_2 && rd_ok_2) ? 2'd2 : 2'd1;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(nw);
      rd_ptr_d = rd_ptr_q + PTR_W'(np);
      count_d  = count_q + (PTR_W+1)'(nw) - (PTR_W+1)'(np);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately not reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (we_1) mem_q[wr_ptr_q]  <= w_data_1;
      if (we_2) mem_q[wr_ptr_p1] <= w_data_2;
   end

   assign fifo_full        = full;
   assign fifo_r_data_1_ok = rd_ok_1;
   assign fifo_r_data_2_ok = rd_ok_2;
   assign fifo_r_data_1    = rd_ok_1 ? mem_q[rd_ptr_q]  : '0;
   assign fifo_r_data_2    = rd_ok_2 ? mem_q[rd_ptr_p1] : '0;

`ifdef INST_FIFO_COUNT_EN
   assign fifo_count = count_q;
`endif

endmodule

// File: tb/tb_inst_fifo.sv
// Self-checking bench for inst_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_inst_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic        clk;
   logic        rst;
   logic        flush;
   logic [63:0] w_data_1;
   logic        w_data_1_ok;
   logic [63:0] w_data_2;
   logic        w_data_2_ok;
   logic        fifo_full;
   logic [63:0] fifo_r_data_1;
   logic        fifo_r_data_1_ok;
   logic [63:0] fifo_r_data_2;
   logic        fifo_r_data_2_ok;
   logic        p_data_1;
   logic        p_data_2;
`ifdef INST_FIFO_COUNT_EN
   logic [PTR_W:0] fifo_count;
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [63:0] model_q [$];

   inst_fifo #(.DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .w_data_1         (w_data_1),
      .w_data_1_ok      (w_data_1_ok),
      .w_data_2         (w_data_2),
      .w_data_2_ok      (w_data_2_ok),
      .fifo_full        (fifo_full),
      .fifo_r_data_1    (fifo_r_data_1),
      .fifo_r_data_1_ok (fifo_r_data_1_ok),
      .fifo_r_data_2    (fifo_r_data_2),
      .fifo_r_data_2_ok (fifo_r_data_2_ok),
      .p_data_1         (p_data_1),
      .p_data_2         (p_data_2)
`ifdef INST_FIFO_COUNT_EN
      ,
      .fifo_count       (fifo_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs derived purely from the queue contents.
   task automatic check_model(input string tag);
      int unsigned n;
      n = model_q.size();
      check({tag, ".ok1"},  64'(fifo_r_data_1_ok), 64'(n >= 1));
      check({tag, ".ok2"},  64'(fifo_r_data_2_ok), 64'(n >= 2));
      check({tag, ".d1"},   fifo_r_data_1, (n >= 1) ? model_q[0] : 64'd0);
      check({tag, ".d2"},   fifo_r_data_2, (n >= 2) ? model_q[1] : 64'd0);
      check({tag, ".full"}, 64'(fifo_full), 64'((DEPTH - n) < 2));
`ifdef INST_FIFO_COUNT_EN
      check({tag, ".count"}, 64'(fifo_count), 64'(n));
`endif
   endtask

   task automatic model_step(input bit w1ok, input logic [63:0] w1, input bit w2ok,
                             input logic [63:0] w2, input bit p1, input bit p2, input bit fl);
      bit full_now;
      logic [63:0] dummy;
      if (fl) begin
         model_q.delete();
         return;
      end
      full_now = (DEPTH - model_q.size()) < 2;
      if (p1 && model_q.size() >= 1) begin
         dummy = model_q.pop_front();
         if (p2 && model_q.size() >= 1) dummy = model_q.pop_front();
      end
      if (!full_now && w1ok) begin
         model_q.push_back(w1);
         if (w2ok) model_q.push_back(w2);
      end
   endtask

   // Drive at the falling edge, update the model at the rising edge, compare at the next falling edge.
   task automatic cycle(input bit w1ok, input logic [63:0] w1, input bit w2ok,
                        input logic [63:0] w2, input bit p1, input bit p2, input bit fl,
                        input string tag);
      w_data_1_ok = w1ok; w_data_1 = w1;
      w_data_2_ok = w2ok; w_data_2 = w2;
      p_data_1 = p1; p_data_2 = p2; flush = fl;
      @(posedge clk);
      model_step(w1ok, w1, w2ok, w2, p1, p2, fl);
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic idle(input string tag);
      cycle(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      model_q.delete();
      rst = 1'b0;
      check_model("reset");
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      w_data_1 = '0; w_data_1_ok = 1'b0; w_data_2 = '0; w_data_2_ok = 1'b0;
      p_data_1 = 1'b0; p_data_2 = 1'b0;
      do_reset();
      check("reset_ok1_lit", 64'(fifo_r_data_1_ok), 64'd0);
      check("reset_full_lit", 64'(fifo_full), 64'd0);
      idle("idle"); idle("idle");

      // Dual write, then dual pop
      cycle(1'b1, 64'hBFC00000_24010001, 1'b1, 64'hBFC00004_24020002, 1'b0, 1'b0, 1'b0, "dual_wr");
      check("dual_wr_d1_lit", fifo_r_data_1, 64'hBFC00000_24010001);
      check("dual_wr_d2_lit", fifo_r_data_2, 64'hBFC00004_24020002);
      cycle(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, "dual_pop");
      check("dual_pop_ok1_lit", 64'(fifo_r_data_1_ok), 64'd0);
      check("dual_pop_ok2_lit", 64'(fifo_r_data_2_ok), 64'd0);

      // Asynchronous reset mid-cycle with entries present
      cycle(1'b1, 64'h11, 1'b1, 64'h22, 1'b0, 1'b0, 1'b0, "pre_rst");
      #2 rst = 1'b1;
      #1;
      check("async_rst_ok1", 64'(fifo_r_data_1_ok), 64'd0);
      check("async_rst_ok2", 64'(fifo_r_data_2_ok), 64'd0);
      check("async_rst_d1",  fifo_r_data_1, 64'd0);
      check("async_rst_full", 64'(fifo_full), 64'd0);
      model_q.delete();
      @(negedge clk);
      rst = 1'b0;
      check_model("post_rst");
      idle("post_rst_idle");

      // Fill with eight dual writes, then a dropped write while full
      for (int i = 0; i < 8; i++)
         cycle(1'b1, 64'(100 + 2*i), 1'b1, 64'(101 + 2*i), 1'b0, 1'b0, 1'b0, "fill");
      check("fill_full_lit", 64'(fifo_full), 64'd1);
      cycle(1'b1, 64'hDEAD, 1'b1, 64'hBEEF, 1'b0, 1'b0, 1'b0, "wr_full");
      check("wr_full_d1_lit", fifo_r_data_1, 64'd100);
      for (int i = 0; i < 8; i++)
         cycle(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, "drain");
      check("drain_ok1_lit", 64'(fifo_r_data_1_ok), 64'd0);

      // Pointer wrap from index 14/15 to 0
      do_reset();
      for (int i = 0; i < 14; i++)
         cycle(1'b1, 64'(i), 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, "wrap_prep");
      idle("wrap_prep_last");
      cycle(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, "wrap_pop_last");
      check("wrap_empty_lit", 64'(fifo_r_data_1_ok), 64'd0);
      cycle(1'b1, 64'hA0, 1'b1, 64'hA1, 1'b0, 1'b0, 1'b0, "wrap_wr1");
      cycle(1'b1, 64'hA2, 1'b1, 64'hA3, 1'b0, 1'b0, 1'b0, "wrap_wr2");
      check("wrap_d1_lit", fifo_r_data_1, 64'hA0);
      check("wrap_d2_lit", fifo_r_data_2, 64'hA1);
      cycle(1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, "wrap_pop");
      check("wrap_d1b_lit", fifo_r_data_1, 64'hA2);
      check("wrap_d2b_lit", fifo_r_data_2, 64'hA3);

      // Simultaneous dual write and single pop at count=3
      do_reset();
      cycle(1'b1, 64'h31, 1'b1, 64'h32, 1'b0, 1'b0, 1'b0, "c3_a");
      cycle(1'b1, 64'h33, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, "c3_b");
      cycle(1'b1, 64'h34, 1'b1, 64'h35, 1'b1, 1'b0, 1'b0, "wr_pop");
      check("wr_pop_d1_lit", fifo_r_data_1, 64'h32);
      check("wr_pop_size_lit", 64'(model_q.size()), 64'd4);
      cycle(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, "p2_only");
      check("p2_only_d1_lit", fifo_r_data_1, 64'h32);

      // Flush coincident with a dual write at count=5
      cycle(1'b1, 64'h36, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, "c5");
      cycle(1'b1, 64'h37, 1'b1, 64'h38, 1'b1, 1'b1, 1'b1, "flush");
      check("flush_ok1_lit", 64'(fifo_r_data_1_ok), 64'd0);
      check("flush_ok2_lit", 64'(fifo_r_data_2_ok), 64'd0);
      idle("post_flush");

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit w1ok, w2ok, p1, p2, fl;
         w1ok = ($urandom_range(0, 3) != 0);
         w2ok = $urandom_range(0, 1) == 1;
         p1   = ($urandom_range(0, 2) != 0);
         p2   = $urandom_range(0, 1) == 1;
         fl   = ($urandom_range(0, 60) == 0);
         cycle(w1ok, {$urandom, $urandom}, w2ok, {$urandom, $urandom}, p1, p2, fl, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_fifo.md
# inst_fifo

Instruction queue between the fetch unit and the issue stage. Fetch writes up to two {pc, inst} entries per cycle. The head two entries are presented to issue as `fifo_r_data_1/_2` with valid flags, and are retired by the issue stage's `p_data_1/_2` pop strobes. The queue decouples fetch stalls from decode stalls and is cleared on a pipeline flush (branch redirect or exception).

## Interface
- `DEPTH`, 16: number of 64-bit entries; must be a power of two and ≥ 4.
- `PTR_W`, `$clog2(DEPTH)`: pointer width. Derived; never overridden.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  discards all entries; highest priority.
- `w_data_1`  in  64  first write entry, {pc[63:32], inst[31:0]}.
- `w_data_1_ok`  in  1  `w_data_1` valid.
- `w_data_2`  in  64  second write entry; sequentially follows `w_data_1`.
- `w_data_2_ok`  in  1  `w_data_2` valid; honoured only when `w_data_1_ok` is high.
- `fifo_full`  out  1  free slots < 2; fetch must not write while high.
- `fifo_r_data_1`  out  64  head entry; 0 when `fifo_r_data_1_ok` is low.
- `fifo_r_data_1_ok`  out  1  count ≥ 1.
- `fifo_r_data_2`  out  64  head+1 entry; 0 when `fifo_r_data_2_ok` is low.
- `fifo_r_data_2_ok`  out  1  count ≥ 2.
- `p_data_1`  in  1  pop head entry.
- `p_data_2`  in  1  pop head+1 entry; honoured only together with an honoured `p_data_1`.

## Operation
- Storage: circular buffer `mem[DEPTH]` of 64 bits, with `wr_ptr` and `rd_ptr` (`PTR_W` bits, natural wrap) and `count` (`PTR_W+1` bits, 0..DEPTH). Memory contents are not reset.
- Write count `nw`:
  - 2 if `w_data_1_ok` && `w_data_2_ok`;
  - 1 if only `w_data_1_ok`;
  - 0 otherwise.
- `w_data_1` goes to `mem[wr_ptr]` and `w_data_2` goes to `mem[wr_ptr+1]` (wrapping). `wr_ptr` advances by `nw`.
- Writes presented while `fifo_full`=1 are dropped entirely: `nw` forced to 0, and no partial write takes place.
- Pop count `np`:
  - 2 if `p_data_1` && `fifo_r_data_1_ok` && `p_data_2` && `fifo_r_data_2_ok`;
  - 1 if only the first pair is true;
  - 0 otherwise.
- A pop of an invalid slot is ignored. `rd_ptr` advances by `np`.
- `count` next value = `count` + `nw` − `np`. Simultaneous write and pop is always legal. With `fifo_full` as the gate, `count` can never exceed DEPTH, and `np` ≤ `count` guarantees no underflow.
- Read outputs are combinational from `mem[rd_ptr]` and `mem[rd_ptr+1]`, gated by the ok flags.
- `flush`=1: next-cycle `wr_ptr`=`rd_ptr`=`count`=0. Same-cycle writes and pops are discarded.
- Reset (async, `rst`=1): `wr_ptr`=`rd_ptr`=`count`=0. Consequently `fifo_r_data_*_ok`=0, `fifo_r_data_*`=0, and `fifo_full`=0 immediately, without waiting for a clock. Reset mid-operation loses all entries.

## Timing
- Write-to-read latency is 1 cycle: an entry written at edge N is visible on `fifo_r_data_*` after edge N.
- There is no bypass from `w_data` to `r_data` in the same cycle.
- The pop takes effect at the clock edge; the next head entry appears after that edge.
- `fifo_full`, the ok flags and the read data depend only on registered state. There is no combinational path from the `p_data_*` or `w_data_*` inputs to any output.
- `fifo_full` = (DEPTH − `count`) < 2, computed on current state. A pop in the same cycle does not relieve full until the next cycle.
- Pointer wrap: at `wr_ptr`=DEPTH−1 a dual write places `w_data_2` at index 0. The same wrap rule applies to `rd_ptr`+1.

## Configuration
- `INST_FIFO_COUNT_EN`:
  - When defined, adds output port `fifo_count` (`PTR_W+1` bits), equal to the registered `count`. It is 0 on reset and 0 the cycle after a flush. Intended for performance counters and debug.
  - When undefined, the port does not exist and behaviour is otherwise identical.

## Test plan
- Reset then idle: assert `rst` mid-cycle → ok flags 0, data 0 and `fifo_full` 0 immediately; they stay so with no writes.
- Dual write {0xBFC00000, 0x24010001} and {0xBFC00004, 0x24020002}, no pops → next cycle both ok=1 with exact data. Pop both → both ok=0 on the following cycle.
- Fill DEPTH=16 with eight dual writes → `fifo_full`=1 once count=15 or 16. A further write while full is dropped and count is unchanged.
- Wrap: after 14 single writes and 14 pops (ptrs=14), do two dual writes → entries read back in order across index 15→0.
- Simultaneous dual write and single pop at count=3 → count=4 and the head advances by one. `p_data_2` with `p_data_1`=0 → no pop.
- Flush coincident with a dual write at count=5 → next cycle count=0 and both ok=0. With `INST_FIFO_COUNT_EN`, `fifo_count` = 0.
